// File: rtl/eeprom_ctrl.sv
// Initiator-side sequencer for a 16x8 combinational-read EEPROM array.
// Optional write read-back check enabled by defining EEPROM_CTRL_VERIFY_EN.
module eeprom_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int PROG_CYCLES = 4,
  parameter int READ_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_erase,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int MAX_CYC = (PROG_CYCLES > READ_CYCLES) ? PROG_CYCLES : READ_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] PROG_LOAD = CNT_W'(PROG_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LOAD = CNT_W'(READ_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_PROG,
    S_READ,
`ifdef EEPROM_CTRL_VERIFY_EN
    S_VERIFY,
`endif
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_write_q, is_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                erase_q, erase_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      erase_q    <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      erase_q    <= erase_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Strobes are computed from the next state so they come straight off flops.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    erase_d    = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d     = cmd_addr;
          wdata_d    = cmd_wdata;
          is_write_d = (cmd_op == 2'b01);
          case (cmd_op)
            2'b00: begin
              state_d = S_READ;
              cnt_d   = READ_LOAD;
            end
            2'b01, 2'b10: begin
              state_d = S_ERASE;
              cnt_d   = PROG_LOAD;
              erase_d = 1'b1;
            end
            default: begin
              state_d    = S_DONE;
              rsp_data_d = '0;
              rsp_err_d  = 1'b1;
            end
          endcase
        end
      end

      S_ERASE: begin
        if (cnt_q == '0) begin
          if (is_write_q) begin
            state_d = S_PROG;
            cnt_d   = PROG_LOAD;
            we_d    = 1'b1;
          end else begin
            state_d    = S_DONE;
            rsp_data_d = '0;
            rsp_err_d  = 1'b0;
          end
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          erase_d = 1'b1;
        end
      end

      S_PROG: begin
        if (cnt_q == '0) begin
`ifdef EEPROM_CTRL_VERIFY_EN
          state_d = S_VERIFY;
          cnt_d   = READ_LOAD;
`else
          state_d    = S_DONE;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          we_d  = 1'b1;
        end
      end

      S_READ: begin
        if (cnt_q == '0) begin
          state_d    = S_DONE;
          rsp_data_d = mem_rdata;
          rsp_err_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

`ifdef EEPROM_CTRL_VERIFY_EN
      S_VERIFY: begin
        if (cnt_q == '0) begin
          state_d    = S_DONE;
          rsp_data_d = mem_rdata;
          rsp_err_d  = (mem_rdata != wdata_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_erase = erase_q;

endmodule
